// File: rtl/i2c_master_pkg.sv
// Shared I2C master definitions: master FSM state encoding and SCL timing defaults.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE            = 4'd0,
    ST_READY           = 4'd1,
    ST_SEND_ADDRESS    = 4'd2,
    ST_CHECK_ACK       = 4'd3,
    ST_WRITE_DATA      = 4'd4,
    ST_OUTPUT_DATA     = 4'd5,
    ST_READ_DATA       = 4'd6,
    ST_STORE_DATA      = 4'd7,
    ST_SEND_ACK        = 4'd8,
    ST_SEND_NACK       = 4'd9,
    ST_CHECK_FOR_VALID = 4'd10,
    ST_STOP            = 4'd11
  } master_state_t;

  localparam int T_LOW_DEF     = 6;
  localparam int T_HIGH_DEF    = 4;
  localparam int THRESHOLD_DEF = 2;

  // States in which bit_idx counts completed bit periods.
  function automatic logic is_shift_state(input logic [3:0] s);
    return (s == ST_SEND_ADDRESS) || (s == ST_OUTPUT_DATA) ||
           (s == ST_READ_DATA)    || (s == ST_STORE_DATA);
  endfunction

endpackage

// File: rtl/i2c_bit_shifter.sv
// Byte register with parallel load and MSB-first shift (serial-in at LSB).
module i2c_bit_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              shift,
  input  logic              shift_in,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[DATA_W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/i2c_sda_ctrl.sv
// I2C master SDA data path: START/STOP generation, byte shift-out, ACK and read-byte sampling,
// all timed from the master state and the scl_generate phase counter.
module i2c_sda_ctrl
  import i2c_master_pkg::*;
#(
  parameter int T_LOW     = T_LOW_DEF,
  parameter int T_HIGH    = T_HIGH_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF,
  parameter int DRIVE_PT  = 2,
  parameter int SAMPLE_PT = 8,
  parameter int START_PT  = 1,
  parameter int STOP_REL  = 6,
  parameter int DATA_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state_master,
  input  logic [6:0] count_ctrl,
  input  logic [6:0] tx_addr,
  input  logic       tx_rw,
  input  logic [7:0] tx_data,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ack_ok,
  output logic       ack_err,
  output logic [3:0] bit_idx
);

  localparam logic [6:0] DRIVE_C   = 7'(DRIVE_PT);
  localparam logic [6:0] SAMPLE_C  = 7'(SAMPLE_PT);
  localparam logic [6:0] START_C   = 7'(START_PT);
  localparam logic [6:0] BIT_END_C = 7'(T_LOW + T_HIGH - 1);
  // The release must land after scl_generate has raised SCL in Stop; clamp an early setting.
  localparam logic [6:0] STOP_C    = 7'((STOP_REL > 2*THRESHOLD) ? STOP_REL : 2*THRESHOLD + 1);
  localparam logic [3:0] LEN_C     = 4'(DATA_LEN);

  logic [3:0] state_q;
  logic       entry, at_drive, at_sample, at_bit_end, bits_left, last_bit;
  logic       tx_load, tx_shift, rx_load, rx_shift;
  logic [7:0] tx_load_val, tx_q, rx_q;
  logic       ack_done, rx_pend;
  logic       unused_bits;

  assign entry      = (state_master != state_q);
  assign at_drive   = !entry && (count_ctrl == DRIVE_C);
  assign at_sample  = !entry && (count_ctrl == SAMPLE_C);
  assign at_bit_end = !entry && (count_ctrl == BIT_END_C);
  assign bits_left  = (bit_idx < LEN_C);
  assign last_bit   = (bit_idx == LEN_C - 4'd1);

  assign tx_load     = entry && ((state_master == ST_SEND_ADDRESS) || (state_master == ST_WRITE_DATA));
  assign tx_load_val = (state_master == ST_SEND_ADDRESS) ? {tx_addr, tx_rw} : tx_data;
  assign tx_shift    = at_drive && bits_left &&
                       ((state_master == ST_SEND_ADDRESS) || (state_master == ST_OUTPUT_DATA));
  assign rx_load     = entry && (state_master == ST_READ_DATA);
  assign rx_shift    = at_sample && bits_left &&
                       ((state_master == ST_READ_DATA) || (state_master == ST_STORE_DATA));
  assign unused_bits = ^{tx_q[6:0], rx_q[7]};

  i2c_bit_shifter #(.DATA_W(8)) u_tx_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .load_val (tx_load_val),
    .shift    (tx_shift),
    .shift_in (1'b0),
    .q        (tx_q)
  );

  i2c_bit_shifter #(.DATA_W(8)) u_rx_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rx_load),
    .load_val (8'h00),
    .shift    (rx_shift),
    .shift_in (sda_in),
    .q        (rx_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_pend  <= 1'b0;
      ack_ok   <= 1'b0;
      ack_err  <= 1'b0;
      ack_done <= 1'b0;
      bit_idx  <= '0;
    end else begin
      state_q  <= state_master;
      ack_ok   <= 1'b0;
      ack_err  <= 1'b0;
      rx_pend  <= rx_shift && last_bit;
      rx_valid <= rx_pend;
      if (rx_shift && last_bit) rx_data <= {rx_q[6:0], sda_in};

      // Store_Data continues the byte started in Read_Data, so its count is kept.
      if (entry) begin
        ack_done <= 1'b0;
        if (!((state_master == ST_STORE_DATA) && (state_q == ST_READ_DATA))) bit_idx <= '0;
      end else if (is_shift_state(state_master) && at_bit_end && bits_left) begin
        bit_idx <= bit_idx + 4'd1;
      end

      case (state_master)
        ST_IDLE:                         sda_oe <= 1'b0;
        ST_READY:                        if (!entry && (count_ctrl == START_C)) sda_oe <= 1'b1;
        ST_SEND_ADDRESS, ST_OUTPUT_DATA: if (at_drive) sda_oe <= bits_left ? ~tx_q[7] : 1'b0;
        ST_CHECK_ACK: begin
          if (at_drive) sda_oe <= 1'b0;
          if (at_sample && !ack_done) begin
            ack_ok   <= ~sda_in;
            ack_err  <= sda_in;
            ack_done <= 1'b1;
          end
        end
        ST_READ_DATA, ST_STORE_DATA:     if (!entry) sda_oe <= 1'b0;
        ST_SEND_ACK:                     if (at_drive) sda_oe <= 1'b1;
        ST_SEND_NACK:                    if (at_drive) sda_oe <= 1'b0;
        ST_WRITE_DATA, ST_CHECK_FOR_VALID: begin
        end
        ST_STOP: begin
          if (entry)                         sda_oe <= 1'b1;
          else if (count_ctrl == STOP_C)     sda_oe <= 1'b0;
        end
        default:                         sda_oe <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_sda_ctrl.sv
// Directed bench for i2c_sda_ctrl: stimulus queues expected output events, a monitor checks them.
module tb_i2c_sda_ctrl;
  import i2c_master_pkg::*;

  localparam int EV_NONE = 0, EV_OE = 1, EV_ACK_OK = 2, EV_ACK_ERR = 3, EV_RXV = 4;
  // Address byte {7'h50, 0} = 1010_0000 MSB-first; sda_oe is its complement per bit.
  localparam logic [7:0] ADDR_OE  = 8'b0101_1111;
  localparam logic [7:0] READ_BITS = 8'b1010_0101;

  typedef struct {
    int         kind;
    logic [7:0] val;
    int         stamp;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state_master = 4'd0;
  logic [6:0] count_ctrl = 7'd0;
  logic [6:0] tx_addr = 7'd0;
  logic       tx_rw = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       sda_in = 1'b1;
  logic       sda_oe, rx_valid, ack_ok, ack_err;
  logic [7:0] rx_data;
  logic [3:0] bit_idx;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  logic prev_oe = 1'b0;
  logic exp_oe = 1'b0;
  ev_t exp_q[$];

  i2c_sda_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .state_master (state_master),
    .count_ctrl   (count_ctrl),
    .tx_addr      (tx_addr),
    .tx_rw        (tx_rw),
    .tx_data      (tx_data),
    .sda_in       (sda_in),
    .sda_oe       (sda_oe),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .ack_ok       (ack_ok),
    .ack_err      (ack_err),
    .bit_idx      (bit_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input logic [7:0] val, input int stamp);
    ev_t e;
    e.kind = kind; e.val = val; e.stamp = stamp;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [7:0] val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: unexpected kind=%0d val=%0h at cycle %0d, required no event", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || (e.stamp >= 0 && e.stamp != cyc)) begin
        n_fail++;
        $display("FAIL event: got kind=%0d val=%0h cycle=%0d, required kind=%0d val=%0h cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.stamp);
      end
    end
  endtask

  // Monitor: every sda_oe change and every pulse-cycle is an event to be matched.
  always @(negedge clk) begin
    if (sda_oe !== prev_oe) check_ev(EV_OE, {7'd0, sda_oe});
    prev_oe = sda_oe;
    if (ack_ok)   check_ev(EV_ACK_OK, 8'h00);
    if (ack_err)  check_ev(EV_ACK_ERR, 8'h00);
    if (rx_valid) check_ev(EV_RXV, rx_data);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic [6:0] c);
    state_master = s;
    count_ctrl   = c;
    @(posedge clk);
    #1;
  endtask

  // One bit period (count 0..9). Optional drive expectation at count 2, pulse expectation at count 8.
  task automatic period(input logic [3:0] s, input logic drv, input logic oe_new, input logic bit_v,
                        input int pk, input logic [7:0] pv);
    for (int c = 0; c < 10; c++) begin
      sda_in = bit_v;
      if (drv && c == 2 && oe_new !== exp_oe) begin
        push(EV_OE, {7'd0, oe_new}, cyc + 1);
        exp_oe = oe_new;
      end
      if (c == 8 && pk != EV_NONE) push(pk, pv, (pk == EV_RXV) ? cyc + 2 : cyc + 1);
      step(s, 7'(c));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_pulses", {5'd0, rx_valid, ack_ok, ack_err}, 8'h00);
    chk("reset_bit_idx", {4'd0, bit_idx}, 8'h00);
    rst_n = 1'b1;
    step(ST_IDLE, 7'd0);

    // Async reset in the middle of an Output_Data byte with SDA pulled low.
    tx_data = 8'h00;
    step(ST_WRITE_DATA, 7'd0);
    period(ST_OUTPUT_DATA, 1'b1, 1'b1, 1'b1, EV_NONE, 8'h00);
    step(ST_OUTPUT_DATA, 7'd0);
    chk("out_bit_idx", {4'd0, bit_idx}, 8'h01);
    push(EV_OE, 8'h00, cyc);
    rst_n = 1'b0;
    #1;
    chk("async_sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("async_bit_idx", {4'd0, bit_idx}, 8'h00);
    chk("async_pulses", {5'd0, rx_valid, ack_ok, ack_err}, 8'h00);
    exp_oe = 1'b0;
    state_master = ST_IDLE;
    count_ctrl = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(ST_IDLE, 7'd0);

    // START in Ready.
    step(ST_READY, 7'd0);
    push(EV_OE, 8'h01, cyc + 1);
    step(ST_READY, 7'd1);
    step(ST_READY, 7'd2);
    step(ST_READY, 7'd3);
    exp_oe = 1'b1;
    chk("ready_hold", {7'd0, sda_oe}, 8'h01);

    // Address byte 7'h50 + write.
    tx_addr = 7'h50;
    tx_rw   = 1'b0;
    for (int b = 0; b < 8; b++) period(ST_SEND_ADDRESS, 1'b1, ADDR_OE[7-b], 1'b1, EV_NONE, 8'h00);
    chk("addr_bit_idx", {4'd0, bit_idx}, 8'h08);
    period(ST_SEND_ADDRESS, 1'b1, 1'b0, 1'b1, EV_NONE, 8'h00);
    chk("addr_bit_idx_sat", {4'd0, bit_idx}, 8'h08);

    // ACK, then a second period with no pulse, then NACK after a Send_ACK.
    period(ST_CHECK_ACK, 1'b1, 1'b0, 1'b0, EV_ACK_OK, 8'h00);
    period(ST_CHECK_ACK, 1'b1, 1'b0, 1'b0, EV_NONE, 8'h00);
    period(ST_SEND_ACK, 1'b1, 1'b1, 1'b1, EV_NONE, 8'h00);
    period(ST_CHECK_ACK, 1'b1, 1'b0, 1'b1, EV_ACK_ERR, 8'h00);

    // Read byte 8'hA5, then extra bit periods must not pulse.
    for (int b = 0; b < 8; b++)
      period(ST_READ_DATA, 1'b1, 1'b0, READ_BITS[7-b], (b == 7) ? EV_RXV : EV_NONE, 8'hA5);
    chk("rx_data", rx_data, 8'hA5);
    chk("rx_bit_idx", {4'd0, bit_idx}, 8'h08);
    period(ST_READ_DATA, 1'b1, 1'b0, 1'b0, EV_NONE, 8'h00);
    period(ST_STORE_DATA, 1'b1, 1'b0, 1'b1, EV_NONE, 8'h00);
    chk("rx_data_hold", rx_data, 8'hA5);

    // STOP after Send_NACK, then an undefined state encoding.
    period(ST_SEND_NACK, 1'b1, 1'b0, 1'b1, EV_NONE, 8'h00);
    push(EV_OE, 8'h01, cyc + 1);
    step(ST_STOP, 7'd0);
    for (int c = 1; c < 10; c++) begin
      if (c == 6) push(EV_OE, 8'h00, cyc + 1);
      step(ST_STOP, 7'(c));
    end
    step(ST_READY, 7'd0);
    push(EV_OE, 8'h01, cyc + 1);
    step(ST_READY, 7'd1);
    push(EV_OE, 8'h00, -1);
    step(4'hF, 7'd0);
    step(4'hF, 7'd1);
    step(4'hF, 7'd2);
    chk("illegal_state_oe", {7'd0, sda_oe}, 8'h00);

    step(ST_IDLE, 7'd0);
    step(ST_IDLE, 7'd0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
